// File: rtl/uart_byte_tx.sv
// uart_byte_tx: UART transmitter for the board-to-host serial link.
// Takes one word per valid/ready handshake and shifts it out on tx as
// start bit, data LSB first, optional parity, then one or two stop bits.
// tx comes straight from a flop, so the line only changes on clk edges.

module uart_byte_tx #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,   // 0 = none, 1 = odd, 2 = even
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx
);

  // Clocks per bit, rounded to the nearest integer.
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] DIV_LAST  = BW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  // Reject parameter sets the datapath cannot honour.
  if (DIV < 2) begin : g_bad_div
    $error("uart_byte_tx: DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_byte_tx: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_byte_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q;
  logic   [BW-1:0]        baud_q;
  logic   [CW-1:0]        bit_q;    // data bit index, reused as stop bit index
  logic   [DATA_BITS-1:0] shift_q;
  logic                   parity_q;
  logic                   tx_q;
  logic                   ready_q;

  logic                   parity_d;
  logic                   baud_wrap;

  // Parity of the incoming word, latched only on the accept edge.
  assign parity_d  = (PARITY == 1) ? ~^data : ^data;
  // Last clock of the current bit period.
  assign baud_wrap = (baud_q == DIV_LAST);

  // Frame sequencer: handshake, bit timing and the registered line level.
  // NOTE: every flop here, including the shift register, is updated with
  // non-blocking assignments and cleared by reset so an aborted frame
  // leaves no stale word or half-finished count behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid && ready_q) begin
            shift_q  <= data;
            parity_q <= parity_d;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            state_q  <= S_START;
          end
        end

        S_START: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end

        S_DATA: begin
          if (baud_wrap) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                tx_q    <= parity_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_q   <= bit_q + CW'(1);
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end

        S_PARITY: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end

        S_STOP: begin
          if (baud_wrap) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q   <= '0;
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              bit_q <= bit_q + CW'(1);
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end

        default: begin
          baud_q  <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = ~ready_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: directed bench for uart_byte_tx at DIV = 10.
// Four instances cover no parity, even parity, odd parity and a
// 7-data-bit / 2-stop-bit frame; one is observed at a time through sel.

module tb_uart_byte_tx;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_r;
  logic [3:0] valid_v;
  logic       tx_v    [4];
  logic       ready_v [4];
  logic       busy_v  [4];

  int         sel;
  logic       tx_s;
  logic       ready_s;
  logic       busy_s;

  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  // Route the instance under test onto the observed signals.
  always_comb begin
    tx_s    = tx_v[sel];
    ready_s = ready_v[sel];
    busy_s  = busy_v[sel];
  end

  uart_byte_tx #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
    .clk(clk), .reset(reset), .data(data_r), .valid(valid_v[0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .tx(tx_v[0]));

  uart_byte_tx #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .data(data_r), .valid(valid_v[1]),
    .ready(ready_v[1]), .busy(busy_v[1]), .tx(tx_v[1]));

  uart_byte_tx #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .data(data_r), .valid(valid_v[2]),
    .ready(ready_v[2]), .busy(busy_v[2]), .tx(tx_v[2]));

  uart_byte_tx #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_d7s2 (
    .clk(clk), .reset(reset), .data(data_r[6:0]), .valid(valid_v[3]),
    .ready(ready_v[3]), .busy(busy_v[3]), .tx(tx_v[3]));

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Expected line levels, first bit transmitted in bit 0; unused positions idle high.
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input int nd,
                                           input int has_par, input logic par);
    logic [15:0] f;
    int          p;
    f    = '1;
    f[0] = 1'b0;
    p    = 1;
    for (int i = 0; i < nd; i++) begin
      f[p] = d[i];
      p++;
    end
    if (has_par != 0) f[p] = par;
    return f;
  endfunction

  // Present a word for one clock; returns just after the accept edge.
  task automatic send(input logic [7:0] d);
    data_r       = d;
    valid_v[sel] = 1'b1;
    tick();
    valid_v[sel] = 1'b0;
  endtask

  // Walk a whole frame from the first start-bit clock. Each bit must hold its
  // level for exactly DIV clocks; ready must stay low for the whole frame and
  // be back high once it ends. Optionally pulses valid with inj_data mid-frame.
  task automatic expect_frame(input string tag, input logic [15:0] bits, input int nbits,
                              input int inject_at, input logic [7:0] inj_data);
    int low_ready;
    int c;
    low_ready = 0;
    c         = 0;
    for (int b = 0; b < nbits; b++) begin
      int hits;
      hits = 0;
      for (int k = 0; k < DIV; k++) begin
        if (inject_at >= 0) begin
          if (c == inject_at) begin
            data_r       = inj_data;
            valid_v[sel] = 1'b1;
          end else begin
            valid_v[sel] = 1'b0;
          end
        end
        if (tx_s === bits[b]) hits++;
        if (ready_s === 1'b0 && busy_s === 1'b1) low_ready++;
        tick();
        c++;
      end
      check($sformatf("%s bit%0d", tag, b), hits, DIV);
    end
    check($sformatf("%s busy_clocks", tag), low_ready, nbits * DIV);
    check($sformatf("%s ready_back", tag), int'(ready_s), 1);
    check($sformatf("%s busy_back", tag), int'(busy_s), 0);
  endtask

  initial begin
    int n_tx_hi;
    int n_rdy_hi;
    int n_busy_lo;

    reset   = 1'b1;
    valid_v = '0;
    data_r  = '0;
    sel     = 0;
    repeat (3) tick();
    reset = 1'b0;

    // 1. Idle after reset: line high, ready, not busy for 50 clocks.
    n_tx_hi = 0; n_rdy_hi = 0; n_busy_lo = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_s === 1'b1)    n_tx_hi++;
      if (ready_s === 1'b1) n_rdy_hi++;
      if (busy_s === 1'b0)  n_busy_lo++;
      tick();
    end
    check("idle tx", n_tx_hi, 50);
    check("idle ready", n_rdy_hi, 50);
    check("idle busy", n_busy_lo, 50);

    // 2. 8'hA5, no parity: 0,1,0,1,0,0,1,0,1,1.
    sel = 0;
    send(8'hA5);
    expect_frame("a5", 16'b1111_11_1010_0101_0 >> 0, 10, -1, 8'h00);

    // 3. 8'h07: even parity bit 1, odd parity bit 0, 110-clock frames.
    sel = 1;
    send(8'h07);
    expect_frame("07even", mk_frame(8'h07, 8, 1, 1'b1), 11, -1, 8'h00);
    sel = 2;
    send(8'h07);
    expect_frame("07odd", mk_frame(8'h07, 8, 1, 1'b0), 11, -1, 8'h00);

    // 4. Back-to-back with valid held: 8'h55 then 8'h0F, one idle clock between.
    sel        = 0;
    data_r     = 8'h55;
    valid_v[0] = 1'b1;
    tick();
    data_r = 8'h0F;
    expect_frame("b2b55", mk_frame(8'h55, 8, 0, 1'b0), 10, -1, 8'h00);
    check("b2b gap tx", int'(tx_s), 1);
    tick();
    valid_v[0] = 1'b0;
    expect_frame("b2b0f", mk_frame(8'h0F, 8, 0, 1'b0), 10, -1, 8'h00);

    // 5. 8'hFF with a valid pulse of 8'h00 at clock 35: ignored, nothing queued.
    send(8'hFF);
    expect_frame("ff", mk_frame(8'hFF, 8, 0, 1'b0), 10, 35, 8'h00);
    n_tx_hi = 0; n_rdy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_s === 1'b1)    n_tx_hi++;
      if (ready_s === 1'b1) n_rdy_hi++;
      tick();
    end
    check("ff no_queue tx", n_tx_hi, 20);
    check("ff no_queue ready", n_rdy_hi, 20);

    // 6. Reset at clock 42 of an 8'h00 frame, then 8'h3C goes out clean.
    send(8'h00);
    repeat (41) tick();
    check("abort pre tx", int'(tx_s), 0);
    reset = 1'b1;
    #1;
    check("abort tx", int'(tx_s), 1);
    check("abort ready", int'(ready_s), 1);
    check("abort busy", int'(busy_s), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("after_reset ready", int'(ready_s), 1);
    check("after_reset tx", int'(tx_s), 1);
    send(8'h3C);
    expect_frame("3c", mk_frame(8'h3C, 8, 0, 1'b0), 10, -1, 8'h00);

    // 6b. 7 data bits, 2 stop bits: 7'h2B -> 0,1,1,0,1,0,1,0,1,1 (100 clocks).
    sel = 3;
    send(8'h2B);
    expect_frame("d7s2", 16'b1111_11_0101011_0, 10, -1, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
